// File: rtl/gowin_pkg.sv
// Shared types and widths for the Gowin MSI interrupt controller.
// msi_state_t is the request FSM; MSI_NUM_W is the width of tl_int_msinum.
package gowin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } msi_state_t;

    localparam int MSI_NUM_W   = 5;
    localparam int MSI_MAX_VEC = 32;

endpackage

// File: rtl/msi_rr_pick.sv
// Combinational round-robin selector: first pending vector strictly after last,
// wrapping to the lowest pending vector when nothing above last is pending.
module msi_rr_pick
    import gowin_pkg::*;
#(
    parameter int C_NUM_VEC = 4
) (
    input  logic [C_NUM_VEC-1:0] pending_i,
    input  logic [MSI_NUM_W-1:0] last_i,
    output logic [MSI_NUM_W-1:0] sel_o,
    output logic                 any_o
);

    logic [MSI_NUM_W-1:0] sel_hi;
    logic [MSI_NUM_W-1:0] sel_lo;
    logic                 any_hi;
    logic                 any_lo;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        sel_hi = '0;
        sel_lo = '0;
        any_hi = 1'b0;
        any_lo = 1'b0;
        for (int j = C_NUM_VEC - 1; j >= 0; j--) begin
            if (pending_i[j]) begin
                sel_lo = MSI_NUM_W'(j);
                any_lo = 1'b1;
                if (MSI_NUM_W'(j) > last_i) begin
                    sel_hi = MSI_NUM_W'(j);
                    any_hi = 1'b1;
                end
            end
        end
    end

    assign sel_o = any_hi ? sel_hi : sel_lo;
    assign any_o = any_lo;

endmodule

// File: rtl/gowin_msi_ctrl.sv
// Multi-vector MSI controller for the Gowin PCIe tl_int_* interface: latches
// per-vector events and serves them round-robin with one request outstanding.
module gowin_msi_ctrl
    import gowin_pkg::*;
#(
    parameter int C_NUM_VEC     = 4,
    parameter int C_ACK_TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [C_NUM_VEC-1:0] irq_i,
    input  logic                 msi_en_i,
    output logic                 tl_int_status_o,
    output logic                 tl_int_req_o,
    output logic [MSI_NUM_W-1:0] tl_int_msinum_o,
    input  logic                 tl_int_ack_i,
    output logic [C_NUM_VEC-1:0] pending_o,
    output logic                 busy_o,
    output logic [7:0]           err_cnt_o
);

    localparam logic [15:0]          TMO_LIMIT = 16'(C_ACK_TIMEOUT);
    localparam logic                 TMO_EN    = (C_ACK_TIMEOUT != 0);
    localparam logic [MSI_NUM_W-1:0] LAST_RST  = MSI_NUM_W'(C_NUM_VEC - 1);

    if (C_NUM_VEC < 1 || C_NUM_VEC > MSI_MAX_VEC) begin : g_bad_num_vec
        $error("gowin_msi_ctrl: C_NUM_VEC must be within 1..32");
    end

    msi_state_t           state_q,  state_d;
    logic [C_NUM_VEC-1:0] pending_q, pending_d;
    logic [C_NUM_VEC-1:0] clr;
    logic                 req_q,    req_d;
    logic [MSI_NUM_W-1:0] msinum_q, msinum_d;
    logic [MSI_NUM_W-1:0] last_q,   last_d;
    logic [15:0]          tmr_q,    tmr_d;
    logic [7:0]           err_q,    err_d;
    logic                 busy_q,   busy_d;
    logic                 status_q, status_d;
    logic [MSI_NUM_W-1:0] sel;
    logic                 any;
    logic                 ack_take;
    logic                 abort;

    msi_rr_pick #(
        .C_NUM_VEC (C_NUM_VEC)
    ) u_pick (
        .pending_i (pending_q),
        .last_i    (last_q),
        .sel_o     (sel),
        .any_o     (any)
    );

    // Ack outranks both abort causes, so abort is only evaluated without one.
    assign ack_take = (state_q == REQ) && tl_int_ack_i;
    assign abort    = (state_q == REQ) && !tl_int_ack_i &&
                      (!msi_en_i || (TMO_EN && (tmr_q == TMO_LIMIT)));

    for (genvar g = 0; g < C_NUM_VEC; g++) begin : g_clr
        assign clr[g] = ack_take && (msinum_q == MSI_NUM_W'(g));
    end

    assign pending_d = (pending_q & ~clr) | irq_i;
    assign status_d  = |pending_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (msi_en_i && any) state_d = REQ;
            REQ:     if (ack_take || abort) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d    = (state_d == REQ);
        busy_d   = (state_d != IDLE);
        msinum_d = msinum_q;
        if (state_q == IDLE && state_d == REQ) msinum_d = sel;
        last_d   = ack_take ? msinum_q : last_q;
        tmr_d    = (state_q == REQ) ? tmr_q + 16'd1 : 16'd0;
        err_d    = err_q;
        if (abort && err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            req_q     <= 1'b0;
            msinum_q  <= '0;
            last_q    <= LAST_RST;
            tmr_q     <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            status_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            req_q     <= req_d;
            msinum_q  <= msinum_d;
            last_q    <= last_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            status_q  <= status_d;
        end
    end

    assign tl_int_status_o = status_q;
    assign tl_int_req_o    = req_q;
    assign tl_int_msinum_o = msinum_q;
    assign pending_o       = pending_q;
    assign busy_o          = busy_q;
    assign err_cnt_o       = err_q;

endmodule

// File: doc/gowin_msi_ctrl.md
# gowin_msi_ctrl

Parametrised MSI interrupt controller driving the Gowin PCIe controller `tl_int_*` interface from up to 32 RIFFA-side interrupt sources. It is the multi-vector successor to the single-bit `msi_req`/`msinum` hookup. It latches per-vector events into a pending register and serves them round-robin over a one-outstanding req/ack handshake. It adds an ack timeout and error counter. It sits between `GW5AST_wrapper` and `SerDes_Top` in the Gowin top level.

## Interface
- `C_NUM_VEC`, 4: number of interrupt vectors, 1..32.
- `C_ACK_TIMEOUT`, 1023: cycles to wait for ack before abandoning a request; 0 disables the timeout.

- `clk`  in  1  core/TL clock, shared with the PCIe TL.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq_i`  in  C_NUM_VEC  per-vector event; sampled every cycle, and a high level sets the pending bit.
- `msi_en_i`  in  1  host has enabled MSI (from config space).
- `tl_int_status_o`  out  1  OR of pending; reset 0.
- `tl_int_req_o`  out  1  MSI request to controller; reset 0.
- `tl_int_msinum_o`  out  5  vector number of the current request; zero-extended; reset 0.
- `tl_int_ack_i`  in  1  controller accepted the request; single-cycle pulse.
- `pending_o`  out  C_NUM_VEC  pending register; reset 0.
- `busy_o`  out  1  high in REQ or GAP; reset 0.
- `err_cnt_o`  out  8  saturating timeout/abort count; reset 0.

## Operation
- Pending update, every cycle: `pending <= (pending & ~clr) | irq_i`, where `clr` is the one-hot vector of `sel` when an ack is taken.
  - If a vector raises irq in the same cycle it is acked, the set wins and the vector stays pending.
  - Repeated irqs on an already-pending vector coalesce into one MSI.
- FSM states are IDLE, REQ and GAP.
- IDLE:
  - If `msi_en_i` is high and any pending bit is set, pick `sel` as the first pending vector at or after `(last+1) mod C_NUM_VEC`.
  - Register `tl_int_msinum_o <= sel`, set `tl_int_req_o <= 1` and go to REQ.
  - Otherwise remain in IDLE.
- REQ:
  - `tl_int_req_o` and `tl_int_msinum_o` are held stable.
  - On `tl_int_ack_i`: clear `pending[sel]`, set `last <= sel`, drop req and go to GAP.
  - Else if `msi_en_i` is low: drop req, increment `err_cnt`, go to GAP; pending is kept.
  - Else if the timeout counter reaches `C_ACK_TIMEOUT` (nonzero): drop req, increment `err_cnt`, go to GAP; pending is kept and `last` is unchanged, so the same vector is retried.
  - Ack takes priority over msi_en drop and over timeout when they occur in the same cycle.
- GAP: one mandatory cycle with req low, then go to IDLE.
- `tl_int_ack_i` outside REQ is ignored.
- Timeout counter is 16-bit; cleared on REQ entry; increments each REQ cycle.
- `err_cnt` saturates at 255.
- `last` resets to `C_NUM_VEC-1`, so vector 0 is served first.
- Asserting reset at any point returns all state to reset values immediately, including mid-REQ; pending events are lost.

## Timing
- irq_i high at cycle N → pending set at N+1 → req high at N+2, if in IDLE with msi_en.
- Ack at cycle M → req low and pending cleared at M+1 (GAP) → IDLE at M+2 → next req at M+3.
  - Minimum spacing between requests is 3 cycles.
- Timeout: req falls C_ACK_TIMEOUT+1 cycles after it rose.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `gowin_pkg` holds:
  - `msi_state_t` (IDLE/REQ/GAP);
  - `MSI_NUM_W = 5`;
  - `MSI_MAX_VEC = 32`.
- Sub-module `msi_rr_pick`: combinational round-robin selector taking `(pending, last)` and returning `(sel, any)`, parametrised by `C_NUM_VEC`.
- Elaboration-time assert that `1 <= C_NUM_VEC <= 32`.

## Test plan
- Single event: pulse irq_i[2] once, ack 4 cycles after req.
  - Expect: req at +2 with msinum=2; pending_o=0 after ack; err_cnt=0.
- Round-robin: set irq_i=4'b1011 for one cycle, ack each request immediately.
  - Expect: msinum sequence 0,1,3; requests 3 cycles apart.
- Coalesce and race: hold irq_i[1] for 10 cycles, then raise irq_i[1] again in the cycle ack arrives.
  - Expect: exactly 2 MSIs for vector 1.
- Timeout: C_ACK_TIMEOUT=8, never ack.
  - Expect: req high for 9 cycles, err_cnt increments, retried with same msinum; err_cnt saturates at 255.
- msi_en gating: pending set with msi_en_i=0.
  - Expect: no req, tl_int_status_o=1.
  - Drop msi_en mid-REQ: req falls next cycle, err_cnt+1, pending retained; re-enable → request reissued.
- Reset mid-REQ: assert rst_n low while req=1.
  - Expect: all outputs 0 at once; no request after release until a new irq.
